circle_motion_ctrl: RTL

- Frame-synchronous controller that sequences the `circle` generator's centre and radius inputs.
- Once per frame, during vertical blanking, it:
  - latches the requested radius from the switches;
  - clamps the centre so the circle stays on screen;
  - advances the centre by a fixed step, bouncing off the screen edges;
  - commits all three values together, so no frame is drawn with mixed parameters.
- A debounced push button toggles pause.
- Sits between the board inputs, `VGAcontroller` (`Vcounter`) and `circle` (`Hcentre`/`Vcentre`/`radius`), in the `PixClk` domain.

---
 rtl/circle_motion_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/circle_motion_ctrl.sv
// Frame-synchronous sequencer for the circle generator: latches radius, clamps and
// bounces the centre once per frame in vertical blanking, with a debounced pause button.
module circle_motion_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int STEP            = 2,
  parameter int START_X         = 320,
  parameter int START_Y         = 240,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       PixClk,
  input  logic       Locked,
  input  logic [9:0] Vcounter,
  input  logic       push_btn,
  input  logic [7:0] switch,
  output logic [9:0] Hcentre,
  output logic [9:0] Vcentre,
  output logic [7:0] radius,
  output logic       paused,
  output logic       frame_tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [9:0]         V_START = 10'(V_ACTIVE);
  localparam logic [7:0]         R_MAX   = 8'(V_ACTIVE / 2 - 1);
  localparam logic signed [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic signed [10:0] V_LAST  = 11'(V_ACTIVE - 1);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);

  typedef enum logic [2:0] {S_WAIT, S_LATCH, S_CLAMP, S_MOVE, S_COMMIT} state_t;

  state_t state, state_nxt;
  logic   do_latch, do_clamp, do_move, do_commit;

  logic [9:0]         vcnt_q;
  logic               frame_start;
  logic [7:0]         r_q, r_lim;
  logic signed [10:0] x_q, y_q, r_s, x_hi, y_hi;
  logic signed [10:0] x_clamp, y_clamp, x_move, y_move;
  logic               dx_q, dy_q, x_flip, y_flip;

  logic          sync1, sync2, deb, deb_q;
  logic [CW-1:0] cnt;

  assign frame_start = (Vcounter == V_START) && (vcnt_q != V_START);

  always_ff @(posedge PixClk or negedge Locked) begin
    if (!Locked) state <= S_WAIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (frame_start) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_CLAMP;
      S_CLAMP:  state_nxt = S_MOVE;
      S_MOVE:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    do_latch  = (state == S_LATCH);
    do_clamp  = (state == S_CLAMP);
    do_move   = (state == S_MOVE);
    do_commit = (state == S_COMMIT);
  end

  // Centre arithmetic is 11-bit signed so that x+STEP and edge compares never wrap.
  always_comb begin
    r_lim   = (switch > R_MAX) ? R_MAX : switch;
    r_s     = signed'({3'b000, r_q});
    x_hi    = H_LAST - r_s;
    y_hi    = V_LAST - r_s;
    x_clamp = (x_q < r_s) ? r_s : ((x_q > x_hi) ? x_hi : x_q);
    y_clamp = (y_q < r_s) ? r_s : ((y_q > y_hi) ? y_hi : y_q);

    x_flip = 1'b0;
    if (dx_q) begin
      if (x_q + STEP_S >= x_hi) begin x_move = x_hi; x_flip = 1'b1; end
      else                            x_move = x_q + STEP_S;
    end else begin
      if (x_q <= r_s + STEP_S) begin x_move = r_s; x_flip = 1'b1; end
      else                           x_move = x_q - STEP_S;
    end

    y_flip = 1'b0;
    if (dy_q) begin
      if (y_q + STEP_S >= y_hi) begin y_move = y_hi; y_flip = 1'b1; end
      else                            y_move = y_q + STEP_S;
    end else begin
      if (y_q <= r_s + STEP_S) begin y_move = r_s; y_flip = 1'b1; end
      else                           y_move = y_q - STEP_S;
    end
  end

  always_ff @(posedge PixClk or negedge Locked) begin
    if (!Locked) begin
      vcnt_q     <= '0;
      r_q        <= '0;
      x_q        <= 11'(START_X);
      y_q        <= 11'(START_Y);
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      Hcentre    <= 10'(START_X);
      Vcentre    <= 10'(START_Y);
      radius     <= '0;
      frame_tick <= 1'b0;
    end else begin
      vcnt_q     <= Vcounter;
      frame_tick <= 1'b0;
      if (do_latch) r_q <= r_lim;
      if (do_clamp) begin
        x_q <= x_clamp;
        y_q <= y_clamp;
      end
      if (do_move && !paused) begin
        x_q  <= x_move;
        y_q  <= y_move;
        dx_q <= dx_q ^ x_flip;
        dy_q <= dy_q ^ y_flip;
      end
      if (do_commit) begin
        Hcentre    <= x_q[9:0];
        Vcentre    <= y_q[9:0];
        radius     <= r_q;
        frame_tick <= 1'b1;
      end
    end
  end

  // Counter restarts whenever the synchronized input agrees with the accepted level.
  always_ff @(posedge PixClk or negedge Locked) begin
    if (!Locked) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      cnt    <= '0;
      paused <= 1'b0;
    end else begin
      sync1 <= push_btn;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (deb && !deb_q) paused <= ~paused;
    end
  end

endmodule
